// File: rtl/soc_system_led_sequencer_if.sv
// Avalon-MM slave bus bundle for the LED sequencer register file.
// Transfer rules: the bus has no wait states and no valid/ready pair.
// - A write is accepted on every rising clk edge where chipselect=1 and write_n=0.
// - readdata is a purely combinational function of address, so it is valid in the same cycle.
// - A read has no side effects.
interface soc_system_led_sequencer_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output chipselect, output write_n,
                  output writedata, input readdata);
  modport slave  (input address, input chipselect, input write_n,
                  input writedata, output readdata);
endinterface

// File: rtl/soc_system_led_sequencer.sv
// LED pattern sequencer with the modes static, blink, rotate and bounce.
// A programmable prescaler produces STEP events. The register file sits on an Avalon-MM slave.
module soc_system_led_sequencer #(
  parameter int WIDTH        = 12,
  parameter int PERIOD_W     = 24,
  parameter int RESET_PERIOD = 5000000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  soc_system_led_sequencer_if.slave   bus,
  output logic [WIDTH-1:0]            out_port,
  output logic                        dbg_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_BOUNCE = 2'b11;

  state_t              state_q, state_d;
  logic [2:0]          ctrl_q, ctrl_d;
  logic [WIDTH-1:0]    pattern_q, pattern_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [15:0]         steps_q, steps_d;
  logic [PERIOD_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]    cur_q, cur_d;
  logic                dir_q, dir_d;
  logic                phase_q, phase_d;
  logic [WIDTH-1:0]    out_q, out_d;

  logic                wr;
  logic                step;
  logic                reload;
  logic [PERIOD_W-1:0] period_m1;

  assign wr          = bus.chipselect && !bus.write_n;
  assign out_port    = out_q;
  assign dbg_state_o = (state_q == S_RUN);

  // A PERIOD value of 0 behaves like 1, so the terminal count is 0 in both cases.
  assign period_m1 = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);
  assign step      = (state_q == S_RUN) && (presc_q == period_m1);

  // Register readback. The value depends only on address, and unused bits read as 0.
  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      2'd0: bus.readdata[2:0]          = ctrl_q;
      2'd1: bus.readdata[WIDTH-1:0]    = pattern_q;
      2'd2: bus.readdata[PERIOD_W-1:0] = period_q;
      default: begin
        bus.readdata[31:16]      = steps_q;
        bus.readdata[4 +: WIDTH] = cur_q;
        bus.readdata[1]          = dir_q;
        bus.readdata[0]          = (state_q == S_RUN);
      end
    endcase
  end

  // Next-state logic. A bus write always beats a STEP in the same cycle, and that STEP is dropped.
  always_comb begin
    ctrl_d    = ctrl_q;
    pattern_d = pattern_q;
    period_d  = period_q;
    steps_d   = steps_q;
    presc_d   = presc_q;
    cur_d     = cur_q;
    dir_d     = dir_q;
    phase_d   = phase_q;

    if (wr && bus.address == 2'd0) ctrl_d    = bus.writedata[2:0];
    if (wr && bus.address == 2'd1) pattern_d = bus.writedata[WIDTH-1:0];
    if (wr && bus.address == 2'd2) period_d  = bus.writedata[PERIOD_W-1:0];

    state_d = (ctrl_d[0] && ctrl_d[2:1] != MODE_STATIC) ? S_RUN : S_IDLE;

    // Restart the sequence when the pattern or period changes, or when the mode changes while running.
    reload = wr && ((bus.address == 2'd1) || (bus.address == 2'd2) ||
                    ((bus.address == 2'd0) && (ctrl_d[2:1] != ctrl_q[2:1])));

    if (state_d == S_IDLE || state_q == S_IDLE || reload) begin
      cur_d   = pattern_d;
      presc_d = '0;
      dir_d   = 1'b0;
      phase_d = 1'b1;
    end else if (step) begin
      presc_d = '0;
      if (!wr) begin
        unique case (ctrl_q[2:1])
          MODE_BLINK:  phase_d = ~phase_q;
          MODE_ROTATE: cur_d   = {cur_q[WIDTH-2:0], cur_q[WIDTH-1]};
          MODE_BOUNCE: begin
            if (!dir_q) begin
              if (cur_q[WIDTH-1]) begin
                dir_d = 1'b1;
                cur_d = cur_q >> 1;
              end else begin
                cur_d = cur_q << 1;
              end
            end else begin
              if (cur_q[0]) begin
                dir_d = 1'b0;
                cur_d = cur_q << 1;
              end else begin
                cur_d = cur_q >> 1;
              end
            end
          end
          default: ;
        endcase
      end
    end else begin
      presc_d = presc_q + PERIOD_W'(1);
    end

    if (wr && bus.address == 2'd3) begin
      steps_d = '0;
    end else if (step && !wr && steps_q != 16'hFFFF) begin
      steps_d = steps_q + 16'd1;
    end

    // The LED output is computed from the next state, so it moves on the edge that ends the STEP cycle.
    out_d = (ctrl_d[2:1] == MODE_BLINK && !phase_d) ? '0 : cur_d;
  end

  // State register, with the FSM and registered LED output under asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      pattern_q <= '0;
      period_q  <= PERIOD_W'(RESET_PERIOD);
      steps_q   <= '0;
      presc_q   <= '0;
      cur_q     <= '0;
      dir_q     <= 1'b0;
      phase_q   <= 1'b1;
      out_q     <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      pattern_q <= pattern_d;
      period_q  <= period_d;
      steps_q   <= steps_d;
      presc_q   <= presc_d;
      cur_q     <= cur_d;
      dir_q     <= dir_d;
      phase_q   <= phase_d;
      out_q     <= out_d;
    end
  end

endmodule
